// File: rtl/contador_decrescente_sinc.sv
// Synchronous modulo-MODULO down counter with parallel load, enable, borrow
// output for synchronous cascading, and a one-shot mode that stops at zero.
// Ports:
//   clk    - clock, all state updates on posedge
//   clr    - synchronous active-low reset
//   en     - count enable (decrement by one per enabled edge)
//   load   - parallel load strobe (wins over en)
//   d      - load value, clamped to MODULO-1
//   modo   - 0 = cyclic (wraps to MODULO-1), 1 = one-shot (stops at 0)
//   q      - current count (registered)
//   zero   - combinational, q == 0
//   borrow - combinational, wrap cycle in cyclic mode
//   done   - registered, high while the one-shot FSM sits in DONE
module contador_decrescente_sinc #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MODULO = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             modo,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow,
  output logic             done
);

  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULO);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] load_val;
  logic             q_is_zero;

  // Load value clamped into the legal count range.
  always_comb begin
    load_val = ({1'b0, d} >= MOD_W) ? TOP : d;
  end

  assign q_is_zero = (q_q == '0);

  // Next-state: load > cyclic count > one-shot FSM; reset handled in the flop.
  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    done_d  = done_q;

    if (load) begin
      q_d = load_val;
      if (modo) begin
        state_d = (load_val != '0) ? ST_RUN : ST_DONE;
        done_d  = (load_val == '0);
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    end else if (!modo) begin
      // Cyclic mode keeps the one-shot FSM parked.
      state_d = ST_IDLE;
      done_d  = 1'b0;
      if (en) begin
        q_d = q_is_zero ? TOP : (q_q - WIDTH'(1));
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Waits for a load; en is ignored.
        end
        ST_RUN: begin
          if (en) begin
            // Saturate at zero so one-shot mode can never wrap.
            if (q_q <= WIDTH'(1)) begin
              q_d     = '0;
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              q_d = q_q - WIDTH'(1);
            end
          end
        end
        ST_DONE: begin
          // Holds at zero until the next load.
        end
        default: begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      q_q     <= '0;
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign q      = q_q;
  assign done   = done_q;
  assign zero   = q_is_zero;
  assign borrow = en & ~load & ~modo & q_is_zero;

endmodule

// File: tb/tb_contador_decrescente_sinc.sv
// Testbench for contador_decrescente_sinc (WIDTH=4, MODULO=10): directed
// scenarios followed by random stimulus, checked through a scoreboard queue
// against a behavioural model of the counter.
module tb_contador_decrescente_sinc;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned MODULO = 10;

  logic             clk;
  logic             clr;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             modo;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             borrow;
  logic             done;

  contador_decrescente_sinc #(.WIDTH(WIDTH), .MODULO(MODULO)) dut (
    .clk    (clk),
    .clr    (clr),
    .en     (en),
    .load   (load),
    .d      (d),
    .modo   (modo),
    .q      (q),
    .zero   (zero),
    .borrow (borrow),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int q;
    bit zero;
    bit borrow;
    bit done;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Behavioural model: count value, whether a one-shot countdown is armed,
  // and the done flag.
  int  m_q     = 0;
  bit  m_armed = 1'b0;
  bit  m_done  = 1'b0;
  bit  m_valid = 1'b0;

  task automatic chk(input string name, input int c, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, got, expv);
    end
  endtask

  // Monitor: DUT outputs are stable mid-cycle; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q",      e.cyc, int'(q),      e.q);
        chk("zero",   e.cyc, int'(zero),   int'(e.zero));
        chk("borrow", e.cyc, int'(borrow), int'(e.borrow));
        chk("done",   e.cyc, int'(done),   int'(e.done));
      end
    end
  end

  // One clock cycle: drive inputs, queue the expected outputs for this cycle,
  // then advance the model across the coming edge.
  task automatic cycle(input bit c, input bit e, input bit l, input int dv,
                       input bit m, input bit glitch = 1'b0);
    exp_t x;
    int   v;
    int   nq;
    bit   narmed;
    bit   ndone;
    clr  = c;
    en   = e;
    load = l;
    d    = WIDTH'(dv);
    modo = m;
    if (m_valid) begin
      x.q      = m_q;
      x.zero   = (m_q == 0);
      x.borrow = e && !l && !m && (m_q == 0);
      x.done   = m_done;
      x.cyc    = cyc;
      sb.push_back(x);
    end
    nq = m_q; narmed = m_armed; ndone = m_done;
    if (!c) begin
      nq = 0; narmed = 1'b0; ndone = 1'b0;
    end else if (l) begin
      v      = (dv >= int'(MODULO)) ? int'(MODULO) - 1 : dv;
      nq     = v;
      narmed = m && (v != 0);
      ndone  = m && (v == 0);
    end else if (!m) begin
      narmed = 1'b0;
      ndone  = 1'b0;
      if (e) nq = (m_q + int'(MODULO) - 1) % int'(MODULO);
    end else if (e && m_armed) begin
      nq = (m_q > 0) ? m_q - 1 : 0;
      if (nq == 0) begin
        narmed = 1'b0;
        ndone  = 1'b1;
      end
    end
    if (glitch) begin
      // Short clr pulse between edges must not disturb anything.
      #4;
      clr = 1'b0;
      #1;
      clr = 1'b1;
    end
    @(posedge clk);
    m_q = nq; m_armed = narmed; m_done = ndone;
    if (!c) m_valid = 1'b1;
    cyc++;
    #2;
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; load = 1'b0; d = '0; modo = 1'b0;
    @(posedge clk);
    #2;

    // Reset, then hold with en=0.
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);

    // Cyclic wrap: borrow on the q=0 cycles, ten edges apart.
    for (int i = 0; i < 21; i++) cycle(1, 1, 0, 0, 0);

    // Load clamping and load-over-en priority.
    cycle(1, 0, 1, 13, 0);
    cycle(1, 1, 1, 5, 0);
    cycle(1, 0, 0, 0, 0);

    // One-shot countdown from 3, then extra en edges at zero.
    cycle(1, 0, 1, 3, 1);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);

    // One-shot zero load, then reload to run again.
    cycle(1, 0, 1, 0, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 1, 2, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 1);

    // Reset mid-run overrides load and en; IDLE then ignores en.
    cycle(1, 0, 1, 9, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 1);
    cycle(0, 1, 1, 4, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 1);

    // Mode switches: cyclic counting, then one-shot IDLE holds a nonzero q.
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 0, 0, 0, 1, 1'b1);
    cycle(1, 1, 0, 0, 0, 1'b1);

    // Random stimulus.
    for (int i = 0; i < 2000; i++) begin
      bit rc, re, rl, rm;
      rc = ($urandom_range(0, 39) != 0);
      re = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 5) == 0);
      rm = (($urandom_range(0, 63) == 0) ? !modo : modo);
      cycle(rc, re, rl, int'($urandom_range(0, 15)), rm);
    end
    cycle(1, 0, 0, 0, modo);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL check_count: got %0d expected at least 12", checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
